// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A - B, LSB first, with registered borrow
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, p_sr;
    logic [CW-1:0]    cnt;
    logic             br, d, br_next;
    logic [WIDTH-1:0] p_next;
    always_comb begin
        d       = a_sr[0] ^ b_sr[0] ^ br;
        br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        p_next  = {d, p_sr[WIDTH-1:1]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            p_sr  <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            D     <= '0;
            Bo    <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SHIFT;
                        a_sr  <= A;
                        b_sr  <= B;
                        p_sr  <= '0;
                        cnt   <= '0;
                        br    <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    p_sr <= p_next;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIN;
                        D     <= p_next;
                        Bo    <= br_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed scoreboard bench for the serial subtractor
module tb_serial_subtractor;
    logic       clk = 0, rst = 1, start = 0;
    logic [7:0] A = 0, B = 0, D;
    logic       busy, done, Bo;
    int         errors = 0, checks = 0, done_cnt = 0;
    logic [8:0] sb[$];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .D(D), .Bo(Bo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] dd;
        dd = a - b;
        sb.push_back({a < b, dd});
    endtask

    always @(negedge clk) begin
        if (busy && done) chk("busy_done_overlap", 1, 0);
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else chk("result", {23'd0, Bo, D}, {23'd0, sb.pop_front()});
        end
    end

    task automatic wait_done(output int k, output int nb);
        k = 0;
        nb = 0;
        while (!done && k < 40) begin
            if (busy) nb++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input string tag);
        int k, nb;
        @(negedge clk);
        A = a;
        B = b;
        start = 1;
        push(a, b);
        @(negedge clk);
        start = 0;
        A = ~a;
        B = ~b;
        wait_done(k, nb);
        chk({tag, "_latency"}, k, 8);
        chk({tag, "_busy_cycles"}, nb, 8);
    endtask

    initial begin
        int k, nb, dc;
        logic [7:0] av[4], bv[4];
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_D", D, 0);
        chk("rst_Bo", Bo, 0);

        op(200, 55, "t200_55");
        op(5, 9, "t5_9");
        repeat (3) @(negedge clk);
        chk("hold_D", D, 252);
        chk("hold_Bo", Bo, 1);
        chk("hold_busy", busy, 0);
        chk("hold_done", done, 0);

        op(0, 0, "t0_0");
        op(0, 1, "t0_1");
        op(255, 255, "t255_255");

        @(negedge clk);
        A = 100;
        B = 50;
        start = 1;
        push(100, 50);
        dc = done_cnt;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        A = 3;
        B = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(k, nb);
        chk("ignored_latency", k, 5);
        repeat (12) @(negedge clk);
        chk("ignored_one_done", done_cnt - dc, 1);
        chk("ignored_busy_after", busy, 0);
        chk("ignored_sb_empty", sb.size(), 0);

        @(negedge clk);
        A = 10;
        B = 20;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_D", D, 0);
        chk("abort_Bo", Bo, 0);
        dc = done_cnt;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - dc, 0);
        op(20, 10, "t20_10");

        av = '{8'd77, 8'd3, 8'd128, 8'd250};
        bv = '{8'd7, 8'd200, 8'd128, 8'd251};
        @(negedge clk);
        A = av[0];
        B = bv[0];
        start = 1;
        push(av[0], bv[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) begin
                A = av[i+1];
                B = bv[i+1];
                push(av[i+1], bv[i+1]);
            end else begin
                start = 0;
            end
            wait_done(k, nb);
            chk($sformatf("b2b_period_%0d", i), k, 8);
        end
        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_busy", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
